// File: rtl/smolboi_spi_mul.sv
// SPI slave multiplier: oversamples CS/SCLK/MOSI on CLK, multiplies A*B with a shift-add
// sequence and returns the 2*WIDTH-bit product on MISO. Define SMOLBOI_SIGNED_EN for signed mode.
module smolboi_spi_mul #(
   parameter int unsigned WIDTH = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic CS,
   input  logic SCLK,
   input  logic MOSI,
   output logic MISO
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned CntW = $clog2(PW + 1);

   typedef enum logic [2:0] {StIdle, StRx, StMul, StTx, StDone} state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     shift_q, shift_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              miso_q, miso_d;

   logic cs_meta_q, cs_s_q, cs_prev_q;
   logic sclk_meta_q, sclk_s_q, sclk_prev_q;
   logic mosi_meta_q, mosi_s_q;

   logic             cs_rise, sclk_rise, sclk_fall;
   logic [PW-1:0]    pp;
   logic [WIDTH-1:0] a_op;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cs_meta_q   <= 1'b0;
         cs_s_q      <= 1'b0;
         cs_prev_q   <= 1'b0;
         sclk_meta_q <= 1'b0;
         sclk_s_q    <= 1'b0;
         sclk_prev_q <= 1'b0;
         mosi_meta_q <= 1'b0;
         mosi_s_q    <= 1'b0;
      end else begin
         cs_meta_q   <= CS;
         cs_s_q      <= cs_meta_q;
         cs_prev_q   <= cs_s_q;
         sclk_meta_q <= SCLK;
         sclk_s_q    <= sclk_meta_q;
         sclk_prev_q <= sclk_s_q;
         mosi_meta_q <= MOSI;
         mosi_s_q    <= mosi_meta_q;
      end
   end

   assign cs_rise   = cs_s_q & ~cs_prev_q;
   assign sclk_rise = sclk_s_q & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s_q & sclk_prev_q;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      miso_d  = miso_q;
      pp      = '0;
      a_op    = '0;

      if (!cs_s_q) begin
         state_d = StIdle;
         miso_d  = 1'b0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               miso_d = 1'b0;
               if (cs_rise) begin
                  state_d = StRx;
                  cnt_d   = '0;
                  shift_d = '0;
                  mcand_d = '0;
                  prod_d  = '0;
               end
            end
            StRx: begin
               if (sclk_rise) begin
                  shift_d = {shift_q[PW-2:0], mosi_s_q};
                  if (cnt_q == CntW'(PW - 1)) begin
                     a_op    = shift_d[PW-1:WIDTH];
`ifdef SMOLBOI_SIGNED_EN
                     mcand_d = {{WIDTH{a_op[WIDTH-1]}}, a_op};
`else
                     mcand_d = {{WIDTH{1'b0}}, a_op};
`endif
                     prod_d  = '0;
                     cnt_d   = '0;
                     state_d = StMul;
                  end else begin
                     cnt_d = cnt_q + CntW'(1);
                  end
               end
            end
            StMul: begin
               // shift_q[0] walks through B's bits, LSB first
               pp      = shift_q[0] ? mcand_q : '0;
               shift_d = shift_q >> 1;
               mcand_d = mcand_q << 1;
               if (cnt_q == CntW'(WIDTH - 1)) begin
`ifdef SMOLBOI_SIGNED_EN
                  // B's sign bit carries weight -2^(WIDTH-1)
                  prod_d = prod_q - pp;
`else
                  prod_d = prod_q + pp;
`endif
                  cnt_d   = '0;
                  state_d = StTx;
               end else begin
                  prod_d = prod_q + pp;
                  cnt_d  = cnt_q + CntW'(1);
               end
            end
            StTx: begin
               if (sclk_fall) begin
                  if (cnt_q == CntW'(PW)) begin
                     miso_d  = 1'b0;
                     state_d = StDone;
                  end else begin
                     miso_d = prod_q[PW-1];
                     prod_d = prod_q << 1;
                     cnt_d  = cnt_q + CntW'(1);
                  end
               end
            end
            StDone: begin
               miso_d = 1'b0;
            end
            default: begin
               state_d = StIdle;
               miso_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         shift_q <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         miso_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         miso_q  <= miso_d;
      end
   end

   assign MISO = miso_q;

endmodule

// File: tb/tb_smolboi_spi_mul.sv
// Directed bench for smolboi_spi_mul (WIDTH=4): SPI frames with hand-computed products,
// CS abort and asynchronous reset during TX.
module tb_smolboi_spi_mul;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic CS = 1'b0;
   logic SCLK = 1'b0;
   logic MOSI = 1'b0;
   logic MISO;

   int n_checks = 0;
   int n_errors = 0;

   smolboi_spi_mul #(.WIDTH(4)) u_dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .CS   (CS),
      .SCLK (SCLK),
      .MOSI (MOSI),
      .MISO (MISO)
   );

   always #10 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b, expected %b", tag, got, exp);
      end
   endtask

   // Full frame: 8 bits in on rises, product out on the following 8 rises, then DONE.
   task automatic do_frame(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] tail);
      CS = 1'b1;
      #200;
      for (int i = 0; i < 8; i++) begin
         MOSI = tx[7-i];
         #200 SCLK = 1'b1;
         #200 SCLK = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         #200 SCLK = 1'b1;
         rx[7-i] = MISO;
         #200 SCLK = 1'b0;
      end
      tail = '0;
      for (int i = 0; i < 2; i++) begin
         #200 SCLK = 1'b1;
         tail[i] = MISO;
         #200 SCLK = 1'b0;
      end
      #200;
      tail[2] = MISO;
      CS = 1'b0;
      MOSI = 1'b0;
      #200;
   endtask

   logic [7:0] vec_in  [9];
   logic [7:0] vec_exp [9];
   logic [7:0] rx, tail;

   initial begin
      vec_in[0] = 8'b0001_0110;
      vec_in[1] = 8'b1111_1111;
      vec_in[2] = 8'b0000_1011;
      vec_in[3] = 8'b1111_0010;
      vec_in[4] = 8'b0111_0111;
      vec_in[5] = 8'b1000_0111;
      vec_in[6] = 8'b1000_1000;
      vec_in[7] = 8'b0101_0011;
      vec_in[8] = 8'b1010_0101;
`ifdef SMOLBOI_SIGNED_EN
      vec_exp[0] = 8'b0000_0110;  //  1 *  6 =   6
      vec_exp[1] = 8'b0000_0001;  // -1 * -1 =   1
      vec_exp[2] = 8'b0000_0000;  //  0 * -5 =   0
      vec_exp[3] = 8'b1111_1110;  // -1 *  2 =  -2
      vec_exp[4] = 8'b0011_0001;  //  7 *  7 =  49
      vec_exp[5] = 8'b1100_1000;  // -8 *  7 = -56
      vec_exp[6] = 8'b0100_0000;  // -8 * -8 =  64
      vec_exp[7] = 8'b0000_1111;  //  5 *  3 =  15
      vec_exp[8] = 8'b1110_0010;  // -6 *  5 = -30
`else
      vec_exp[0] = 8'b0000_0110;  //  1 *  6 =   6
      vec_exp[1] = 8'b1110_0001;  // 15 * 15 = 225
      vec_exp[2] = 8'b0000_0000;  //  0 * 11 =   0
      vec_exp[3] = 8'b0001_1110;  // 15 *  2 =  30
      vec_exp[4] = 8'b0011_0001;  //  7 *  7 =  49
      vec_exp[5] = 8'b0011_1000;  //  8 *  7 =  56
      vec_exp[6] = 8'b0100_0000;  //  8 *  8 =  64
      vec_exp[7] = 8'b0000_1111;  //  5 *  3 =  15
      vec_exp[8] = 8'b0011_0010;  // 10 *  5 =  50
`endif

      #1;
      check_eq("reset_miso", {7'b0, MISO}, 8'h00);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (5) @(negedge CLK);
      check_eq("idle_miso", {7'b0, MISO}, 8'h00);

      for (int v = 0; v < 9; v++) begin
         do_frame(vec_in[v], rx, tail);
         check_eq($sformatf("product_%0d", v), rx, vec_exp[v]);
         check_eq($sformatf("done_zero_%0d", v), tail, 8'h00);
      end

      // Abort after 5 bits, then a clean frame must not see leftovers.
      CS = 1'b1;
      #200;
      for (int i = 0; i < 5; i++) begin
         MOSI = 1'b1;
         #200 SCLK = 1'b1;
         #200 SCLK = 1'b0;
      end
      CS = 1'b0;
      MOSI = 1'b0;
      #200;
      check_eq("abort_miso", {7'b0, MISO}, 8'h00);
      do_frame(8'b0010_0011, rx, tail);
      check_eq("after_abort", rx, 8'b0000_0110);
      check_eq("after_abort_done", tail, 8'h00);

      // Reset mid-TX while bit 4 (a 1 in both modes) is on MISO.
      CS = 1'b1;
      #200;
      for (int i = 0; i < 8; i++) begin
         MOSI = vec_in[3][7-i];
         #200 SCLK = 1'b1;
         #200 SCLK = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         #200 SCLK = 1'b1;
         #200 SCLK = 1'b0;
      end
      #150;
      check_eq("tx_bit4", {7'b0, MISO}, 8'h01);
      #5 RST_N = 1'b0;
      #1;
      check_eq("async_reset_miso", {7'b0, MISO}, 8'h00);
      CS = 1'b0;
      SCLK = 1'b0;
      MOSI = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (5) @(negedge CLK);
      check_eq("post_reset_idle", {7'b0, MISO}, 8'h00);
      do_frame(8'b0011_0101, rx, tail);
      check_eq("after_reset", rx, 8'b0000_1111);
      check_eq("after_reset_done", tail, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
